wb_stage_pipe: RTL and testbench
================================

# wb_stage_pipe

Registered, parametrised write-back stage for the pipelined CPU. It captures the MEM/WB pipeline register and selects the register-file write data from four sources: ALU, load data, PC+4 and immediate. It also aligns and sign- or zero-extends sub-word loads, supports stall and flush, drives a forwarding port and keeps a retired-instruction counter. It sits between the memory stage and the register file / hazard unit.

## Interface
- XLEN, 32, datapath width (32 or 64)
- RA_W, 5, register address width
- CNT_W, 64, retired-instruction counter width
- clk  in  1  clock, rising edge
- rst_n  in  1  reset, asynchronous, active-low
- mem_valid  in  1  MEM stage holds a real instruction
- mem_reg_write  in  1  instruction writes rd
- mem_rd  in  RA_W  destination register
- mem_wb_sel  in  2  0 ALU, 1 load, 2 PC+4, 3 immediate
- mem_load_type  in  3  0 LB, 1 LH, 2 LW, 4 LBU, 5 LHU; other codes behave as LW
- mem_addr_lo  in  2  load address bits [1:0]
- mem_alu_out, mem_rdata, mem_pc_plus4, mem_imm  in  XLEN each  source operands
- stall  in  1  hold WB register
- flush  in  1  insert bubble
- rf_we  out  1  register-file write enable
- rf_waddr  out  RA_W  write address
- rf_wdata  out  XLEN  write data
- fwd_valid  out  1  WB holds a valid writing instruction with rd≠0
- fwd_rd  out  RA_W  forwarding address
- fwd_data  out  XLEN  forwarding data, same as rf_wdata
- instret  out  CNT_W  retired-instruction count

## Operation
- The WB register holds: valid, reg_write, rd, wb_sel, load_type, addr_lo, alu_out, rdata, pc_plus4, imm, plus a fresh bit.
- Capture rule, with precedence flush > stall > load:
  - flush: valid←0, fresh←0. Data fields are don't-care.
  - stall: all fields hold; fresh←0.
  - Otherwise: load all fields from mem_*; fresh←mem_valid.
- Load extraction from rdata:
  - LB/LBU: byte lane addr_lo[1:0].
  - LH/LHU: half lane addr_lo[1]; addr_lo[0] is ignored.
  - LW: full low 32 bits.
  - Signed types sign-extend to XLEN. U-types zero-extend.
  - When XLEN=64, LW sign-extends bit 31.
- rf_wdata = mux(wb_sel) of alu_out, extracted load, pc_plus4, imm.
- rf_we = fresh & reg_write & (rd≠0). A held instruction is written exactly once.
- rf_waddr = rd.
- fwd_valid = valid & reg_write & (rd≠0). It stays asserted during stall.
- instret increments by 1 on each cycle where fresh=1, whether or not the instruction writes a register. It wraps modulo 2^CNT_W.

## Timing
- Latency: one cycle. An instruction presented on cycle N is written at the clk edge ending cycle N+1.
- rf_wdata and fwd_data are combinational from the WB register; there is no extra flop.
- Reset, asynchronous: all WB fields←0, so rf_we=0, fwd_valid=0, rf_waddr=0, rf_wdata=0, and instret=0.
- Reset asserted mid-operation discards the held instruction and does not count it.
- flush and stall together: flush wins, giving a bubble.
- Stall released: the next edge loads new MEM content normally.
- Back-to-back valid instructions with no stall give one write per cycle.

## Configuration
- WB_DEBUG_EN defined: adds outputs dbg_wb_sel (2), dbg_alu_out (XLEN), dbg_rdata (XLEN) and dbg_valid (1), each reflecting the WB register.
- WB_DEBUG_EN undefined: these ports do not exist. Functional behaviour is identical either way.

## Structure
- Shared package cpu_pkg holds:
  - wb_sel encodings: WB_ALU, WB_MEM, WB_PC4, WB_IMM.
  - load_type encodings: LD_B, LD_H, LD_W, LD_BU, LD_HU.
  - The default XLEN.
- Sub-module load_align (XLEN parameter) takes rdata, load_type and addr_lo and produces the extended data. It is purely combinational and instantiated once.

## Test plan
- Reset, then ALU op: rd=5, wb_sel=0, alu_out=0x1234 → next cycle rf_we=1, waddr=5, wdata=0x1234, and instret=1.
- Load extraction: rdata=0x80FF7F01.
  - LB, addr_lo=3 → 0xFFFFFF80.
  - LBU, addr_lo=1 → 0x7F.
  - LH, addr_lo=2 → 0xFFFF80FF.
  - LHU, addr_lo=0 → 0x7F01.
- JAL: wb_sel=2, pc_plus4=0x104, rd=1 → wdata=0x104. Same instruction with rd=0 → rf_we=0 and fwd_valid=0, but instret still increments.
- Stall for 3 cycles after a write to rd=7 → rf_we high for 1 cycle only, fwd_valid high for all 4 cycles, instret +1.
- flush and stall together while the MEM stage is valid → next cycle valid=0, rf_we=0, fwd_valid=0, and no count.
- Assert rst_n low asynchronously between edges while WB is valid → outputs clear immediately and instret=0.

Source files
------------

// File: rtl/cpu_pkg.sv
// ----------------------------------------------------------------------------
// cpu_pkg
// Shared definitions for the CPU pipeline:
//   - wb_sel_e    : register-file write-data source select
//   - load_type_e : sub-word load type encodings
//   - XLEN_DEFAULT: default datapath width
// ----------------------------------------------------------------------------
package cpu_pkg;

    localparam int XLEN_DEFAULT = 32;

    typedef enum logic [1:0] {
        WB_ALU = 2'd0,
        WB_MEM = 2'd1,
        WB_PC4 = 2'd2,
        WB_IMM = 2'd3
    } wb_sel_e;

    // Codes 3, 6 and 7 are not listed and are treated as a full word load.
    typedef enum logic [2:0] {
        LD_B  = 3'd0,
        LD_H  = 3'd1,
        LD_W  = 3'd2,
        LD_BU = 3'd4,
        LD_HU = 3'd5
    } load_type_e;

endpackage : cpu_pkg

// File: rtl/load_align.sv
// ----------------------------------------------------------------------------
// load_align
// Purely combinational lane select and extension of load data.
// Ports:
//   rdata     in  XLEN  raw load data from memory
//   load_type in  3     LB/LH/LW/LBU/LHU (unknown codes behave as LW)
//   addr_lo   in  2     load address bits [1:0]
//   ext_data  out XLEN  aligned and sign/zero-extended result
// ----------------------------------------------------------------------------
module load_align
    import cpu_pkg::*;
#(
    parameter int XLEN = XLEN_DEFAULT
) (
    input  logic [XLEN-1:0] rdata,
    input  logic [2:0]      load_type,
    input  logic [1:0]      addr_lo,
    output logic [XLEN-1:0] ext_data
);

    logic [31:0] word_lane;
    logic [15:0] half_lane;
    logic [7:0]  byte_lane;

    always_comb begin
        word_lane = rdata[31:0];

        case (addr_lo)
            2'd0:    byte_lane = word_lane[7:0];
            2'd1:    byte_lane = word_lane[15:8];
            2'd2:    byte_lane = word_lane[23:16];
            default: byte_lane = word_lane[31:24];
        endcase

        // Half-word lane uses addr_lo[1] only; misaligned bit 0 is ignored.
        half_lane = addr_lo[1] ? word_lane[31:16] : word_lane[15:0];

        // Size casts of signed values sign-extend, which also makes LW
        // sign-extend bit 31 when XLEN is 64 and reduce to a copy at 32.
        case (load_type)
            LD_B:    ext_data = XLEN'($signed(byte_lane));
            LD_H:    ext_data = XLEN'($signed(half_lane));
            LD_BU:   ext_data = XLEN'(byte_lane);
            LD_HU:   ext_data = XLEN'(half_lane);
            default: ext_data = XLEN'($signed(word_lane));
        endcase
    end

endmodule : load_align

// File: rtl/wb_stage_pipe.sv
// ----------------------------------------------------------------------------
// wb_stage_pipe
// Registered write-back stage: captures MEM/WB, selects register-file write
// data (ALU / load / PC+4 / immediate), drives a forwarding port and keeps a
// retired-instruction counter.
// Ports:
//   clk, rst_n                   clock, async active-low reset
//   mem_*                        MEM/WB pipeline register inputs
//   stall, flush                 hold WB register / insert bubble
//   rf_we, rf_waddr, rf_wdata    register-file write port
//   fwd_valid, fwd_rd, fwd_data  forwarding port to the hazard unit
//   instret                      retired-instruction count
// Optional: define WB_DEBUG_EN to add dbg_wb_sel, dbg_alu_out, dbg_rdata and
// dbg_valid, each mirroring the WB register.
// ----------------------------------------------------------------------------
module wb_stage_pipe
    import cpu_pkg::*;
#(
    parameter int XLEN  = XLEN_DEFAULT,
    parameter int RA_W  = 5,
    parameter int CNT_W = 64
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             mem_valid,
    input  logic             mem_reg_write,
    input  logic [RA_W-1:0]  mem_rd,
    input  logic [1:0]       mem_wb_sel,
    input  logic [2:0]       mem_load_type,
    input  logic [1:0]       mem_addr_lo,
    input  logic [XLEN-1:0]  mem_alu_out,
    input  logic [XLEN-1:0]  mem_rdata,
    input  logic [XLEN-1:0]  mem_pc_plus4,
    input  logic [XLEN-1:0]  mem_imm,
    input  logic             stall,
    input  logic             flush,
    output logic             rf_we,
    output logic [RA_W-1:0]  rf_waddr,
    output logic [XLEN-1:0]  rf_wdata,
    output logic             fwd_valid,
    output logic [RA_W-1:0]  fwd_rd,
    output logic [XLEN-1:0]  fwd_data,
    output logic [CNT_W-1:0] instret
`ifdef WB_DEBUG_EN
    ,
    output logic [1:0]       dbg_wb_sel,
    output logic [XLEN-1:0]  dbg_alu_out,
    output logic [XLEN-1:0]  dbg_rdata,
    output logic             dbg_valid
`endif
);

    logic             valid_q,     valid_d;
    logic             reg_write_q, reg_write_d;
    logic [RA_W-1:0]  rd_q,        rd_d;
    logic [1:0]       wb_sel_q,    wb_sel_d;
    logic [2:0]       load_type_q, load_type_d;
    logic [1:0]       addr_lo_q,   addr_lo_d;
    logic [XLEN-1:0]  alu_out_q,   alu_out_d;
    logic [XLEN-1:0]  rdata_q,     rdata_d;
    logic [XLEN-1:0]  pc_plus4_q,  pc_plus4_d;
    logic [XLEN-1:0]  imm_q,       imm_d;
    logic             fresh_q,     fresh_d;
    logic [CNT_W-1:0] instret_q,   instret_d;

    logic [XLEN-1:0]  load_data;
    logic [XLEN-1:0]  wdata;
    logic             rd_nz;

    // Capture control: flush beats stall beats load. "fresh" marks the first
    // cycle an instruction sits in WB, so a stalled instruction writes the
    // register file once while still being visible on the forwarding port.
    always_comb begin
        valid_d     = valid_q;
        reg_write_d = reg_write_q;
        rd_d        = rd_q;
        wb_sel_d    = wb_sel_q;
        load_type_d = load_type_q;
        addr_lo_d   = addr_lo_q;
        alu_out_d   = alu_out_q;
        rdata_d     = rdata_q;
        pc_plus4_d  = pc_plus4_q;
        imm_d       = imm_q;
        fresh_d     = 1'b0;

        if (flush) begin
            valid_d = 1'b0;
        end else if (!stall) begin
            valid_d     = mem_valid;
            reg_write_d = mem_reg_write;
            rd_d        = mem_rd;
            wb_sel_d    = mem_wb_sel;
            load_type_d = mem_load_type;
            addr_lo_d   = mem_addr_lo;
            alu_out_d   = mem_alu_out;
            rdata_d     = mem_rdata;
            pc_plus4_d  = mem_pc_plus4;
            imm_d       = mem_imm;
            fresh_d     = mem_valid;
        end

        // The count already includes the instruction retiring this cycle.
        instret_d = instret_q + CNT_W'(fresh_d);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            valid_q     <= 1'b0;
            reg_write_q <= 1'b0;
            rd_q        <= '0;
            wb_sel_q    <= '0;
            load_type_q <= '0;
            addr_lo_q   <= '0;
            alu_out_q   <= '0;
            rdata_q     <= '0;
            pc_plus4_q  <= '0;
            imm_q       <= '0;
            fresh_q     <= 1'b0;
            instret_q   <= '0;
        end else begin
            valid_q     <= valid_d;
            reg_write_q <= reg_write_d;
            rd_q        <= rd_d;
            wb_sel_q    <= wb_sel_d;
            load_type_q <= load_type_d;
            addr_lo_q   <= addr_lo_d;
            alu_out_q   <= alu_out_d;
            rdata_q     <= rdata_d;
            pc_plus4_q  <= pc_plus4_d;
            imm_q       <= imm_d;
            fresh_q     <= fresh_d;
            instret_q   <= instret_d;
        end
    end

    load_align #(
        .XLEN (XLEN)
    ) u_load_align (
        .rdata     (rdata_q),
        .load_type (load_type_q),
        .addr_lo   (addr_lo_q),
        .ext_data  (load_data)
    );

    always_comb begin
        case (wb_sel_q)
            WB_ALU:  wdata = alu_out_q;
            WB_MEM:  wdata = load_data;
            WB_PC4:  wdata = pc_plus4_q;
            default: wdata = imm_q;
        endcase
    end

    assign rd_nz     = (rd_q != '0);
    assign rf_we     = fresh_q & reg_write_q & rd_nz;
    assign rf_waddr  = rd_q;
    assign rf_wdata  = wdata;
    assign fwd_valid = valid_q & reg_write_q & rd_nz;
    assign fwd_rd    = rd_q;
    assign fwd_data  = wdata;
    assign instret   = instret_q;

`ifdef WB_DEBUG_EN
    assign dbg_wb_sel  = wb_sel_q;
    assign dbg_alu_out = alu_out_q;
    assign dbg_rdata   = rdata_q;
    assign dbg_valid   = valid_q;
`endif

endmodule : wb_stage_pipe

// File: tb/tb_wb_stage_pipe.sv
// ----------------------------------------------------------------------------
// tb_wb_stage_pipe
// Directed bench for wb_stage_pipe (XLEN=32, RA_W=5, CNT_W=64). Inputs change
// and outputs are sampled on the falling clock edge; every register-file
// write is matched against an expected-write queue.
// ----------------------------------------------------------------------------
module tb_wb_stage_pipe;

    localparam int XLEN  = 32;
    localparam int RA_W  = 5;
    localparam int CNT_W = 64;

    logic             clk;
    logic             rst_n;
    logic             mem_valid;
    logic             mem_reg_write;
    logic [RA_W-1:0]  mem_rd;
    logic [1:0]       mem_wb_sel;
    logic [2:0]       mem_load_type;
    logic [1:0]       mem_addr_lo;
    logic [XLEN-1:0]  mem_alu_out;
    logic [XLEN-1:0]  mem_rdata;
    logic [XLEN-1:0]  mem_pc_plus4;
    logic [XLEN-1:0]  mem_imm;
    logic             stall;
    logic             flush;
    logic             rf_we;
    logic [RA_W-1:0]  rf_waddr;
    logic [XLEN-1:0]  rf_wdata;
    logic             fwd_valid;
    logic [RA_W-1:0]  fwd_rd;
    logic [XLEN-1:0]  fwd_data;
    logic [CNT_W-1:0] instret;

    int tests_run    = 0;
    int tests_failed = 0;
    logic [XLEN-1:0] exp_q[$];
    logic [CNT_W-1:0] exp_cnt;

    wb_stage_pipe #(
        .XLEN  (XLEN),
        .RA_W  (RA_W),
        .CNT_W (CNT_W)
    ) dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .mem_valid     (mem_valid),
        .mem_reg_write (mem_reg_write),
        .mem_rd        (mem_rd),
        .mem_wb_sel    (mem_wb_sel),
        .mem_load_type (mem_load_type),
        .mem_addr_lo   (mem_addr_lo),
        .mem_alu_out   (mem_alu_out),
        .mem_rdata     (mem_rdata),
        .mem_pc_plus4  (mem_pc_plus4),
        .mem_imm       (mem_imm),
        .stall         (stall),
        .flush         (flush),
        .rf_we         (rf_we),
        .rf_waddr      (rf_waddr),
        .rf_wdata      (rf_wdata),
        .fwd_valid     (fwd_valid),
        .fwd_rd        (fwd_rd),
        .fwd_data      (fwd_data),
        .instret       (instret)
    );

    // ---------------- clock / reset ----------------
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // ---------------- checker ----------------
    task automatic check_val(input string tag, input logic [63:0] obs, input logic [63:0] exp_v);
        tests_run++;
        if (obs !== exp_v) begin
            tests_failed++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp_v);
        end
    endtask

    // ---------------- drivers ----------------
    task automatic drive_idle();
        mem_valid     = 1'b0;
        mem_reg_write = 1'b0;
        mem_rd        = '0;
        mem_wb_sel    = 2'd0;
        mem_load_type = 3'd0;
        mem_addr_lo   = 2'd0;
        mem_alu_out   = '0;
        mem_rdata     = '0;
        mem_pc_plus4  = '0;
        mem_imm       = '0;
    endtask

    task automatic drive_instr(input logic [RA_W-1:0] rd, input logic [1:0] sel,
                               input logic [2:0] lt, input logic [1:0] alo,
                               input logic [XLEN-1:0] alu, input logic [XLEN-1:0] rdat,
                               input logic [XLEN-1:0] pc4, input logic [XLEN-1:0] imm);
        mem_valid     = 1'b1;
        mem_reg_write = 1'b1;
        mem_rd        = rd;
        mem_wb_sel    = sel;
        mem_load_type = lt;
        mem_addr_lo   = alo;
        mem_alu_out   = alu;
        mem_rdata     = rdat;
        mem_pc_plus4  = pc4;
        mem_imm       = imm;
    endtask

    task automatic next_cycle();
        @(negedge clk);
    endtask

    // ---------------- write scoreboard ----------------
    always @(negedge clk) begin
        if (rst_n && rf_we) begin
            if (exp_q.size() == 0) begin
                check_val("unexpected_write", {32'd0, rf_wdata}, 64'hDEAD_0000_0000_0000);
            end else begin
                check_val("sb_wdata", {32'd0, rf_wdata}, {32'd0, exp_q.pop_front()});
            end
        end
    end

    // ---------------- load vectors ----------------
    typedef struct {
        logic [2:0]      lt;
        logic [1:0]      alo;
        logic [XLEN-1:0] exp_v;
    } ld_vec_t;

    ld_vec_t ld_vecs[7];

    initial begin
        ld_vecs[0] = '{3'd0, 2'd3, 32'hFFFF_FF80};  // LB  lane 3
        ld_vecs[1] = '{3'd4, 2'd1, 32'h0000_007F};  // LBU lane 1
        ld_vecs[2] = '{3'd1, 2'd2, 32'hFFFF_80FF};  // LH  upper half
        ld_vecs[3] = '{3'd5, 2'd0, 32'h0000_7F01};  // LHU lower half
        ld_vecs[4] = '{3'd2, 2'd0, 32'h80FF_7F01};  // LW
        ld_vecs[5] = '{3'd0, 2'd0, 32'h0000_0001};  // LB  lane 0
        ld_vecs[6] = '{3'd7, 2'd1, 32'h80FF_7F01};  // unknown code -> LW
    end

    // ---------------- main sequence ----------------
    initial begin
        rst_n = 1'b0;
        stall = 1'b0;
        flush = 1'b0;
        drive_idle();
        exp_cnt = '0;
        repeat (3) next_cycle();

        check_val("rst_rf_we",     {63'd0, rf_we}, 64'd0);
        check_val("rst_fwd_valid", {63'd0, fwd_valid}, 64'd0);
        check_val("rst_waddr",     {59'd0, rf_waddr}, 64'd0);
        check_val("rst_wdata",     {32'd0, rf_wdata}, 64'd0);
        check_val("rst_instret",   instret, 64'd0);

        rst_n = 1'b1;
        next_cycle();

        // ALU write
        drive_instr(5'd5, 2'd0, 3'd2, 2'd0, 32'h1234, 32'h0, 32'h0, 32'h0);
        exp_q.push_back(32'h1234);
        next_cycle();
        exp_cnt = 1;
        check_val("alu_rf_we",    {63'd0, rf_we}, 64'd1);
        check_val("alu_waddr",    {59'd0, rf_waddr}, 64'd5);
        check_val("alu_wdata",    {32'd0, rf_wdata}, 64'h1234);
        check_val("alu_fwd",      {63'd0, fwd_valid}, 64'd1);
        check_val("alu_fwd_rd",   {59'd0, fwd_rd}, 64'd5);
        check_val("alu_fwd_data", {32'd0, fwd_data}, 64'h1234);
        check_val("alu_instret",  instret, exp_cnt);

        // back-to-back loads
        for (int i = 0; i < 7; i++) begin
            drive_instr(5'd10, 2'd1, ld_vecs[i].lt, ld_vecs[i].alo, 32'h0, 32'h80FF_7F01, 32'h0, 32'h0);
            exp_q.push_back(ld_vecs[i].exp_v);
            next_cycle();
            exp_cnt = exp_cnt + 1;
            check_val("load_wdata",   {32'd0, rf_wdata}, {32'd0, ld_vecs[i].exp_v});
            check_val("load_rf_we",   {63'd0, rf_we}, 64'd1);
            check_val("load_instret", instret, exp_cnt);
        end

        // JAL to rd=1, then to rd=0
        drive_instr(5'd1, 2'd2, 3'd2, 2'd0, 32'hAAAA, 32'h0, 32'h104, 32'h0);
        exp_q.push_back(32'h104);
        next_cycle();
        exp_cnt = exp_cnt + 1;
        check_val("jal_wdata", {32'd0, rf_wdata}, 64'h104);
        check_val("jal_waddr", {59'd0, rf_waddr}, 64'd1);

        drive_instr(5'd0, 2'd2, 3'd2, 2'd0, 32'hAAAA, 32'h0, 32'h104, 32'h0);
        next_cycle();
        exp_cnt = exp_cnt + 1;
        check_val("jal_x0_rf_we",   {63'd0, rf_we}, 64'd0);
        check_val("jal_x0_fwd",     {63'd0, fwd_valid}, 64'd0);
        check_val("jal_x0_instret", instret, exp_cnt);

        // immediate source
        drive_instr(5'd3, 2'd3, 3'd2, 2'd0, 32'h1, 32'h2, 32'h3, 32'hDEAD_BEEF);
        exp_q.push_back(32'hDEAD_BEEF);
        next_cycle();
        exp_cnt = exp_cnt + 1;
        check_val("imm_wdata", {32'd0, rf_wdata}, 64'hDEAD_BEEF);

        // stall for 3 cycles after a write to rd=7
        drive_instr(5'd7, 2'd0, 3'd2, 2'd0, 32'h77, 32'h0, 32'h0, 32'h0);
        exp_q.push_back(32'h77);
        next_cycle();
        exp_cnt = exp_cnt + 1;
        check_val("stall_c0_rf_we", {63'd0, rf_we}, 64'd1);
        check_val("stall_c0_fwd",   {63'd0, fwd_valid}, 64'd1);
        stall = 1'b1;
        drive_instr(5'd9, 2'd0, 3'd2, 2'd0, 32'h99, 32'h0, 32'h0, 32'h0);
        for (int i = 0; i < 3; i++) begin
            next_cycle();
            check_val("stall_rf_we",    {63'd0, rf_we}, 64'd0);
            check_val("stall_fwd",      {63'd0, fwd_valid}, 64'd1);
            check_val("stall_fwd_rd",   {59'd0, fwd_rd}, 64'd7);
            check_val("stall_fwd_data", {32'd0, fwd_data}, 64'h77);
            check_val("stall_instret",  instret, exp_cnt);
        end
        // release: the waiting MEM instruction loads normally
        stall = 1'b0;
        exp_q.push_back(32'h99);
        next_cycle();
        exp_cnt = exp_cnt + 1;
        check_val("unstall_waddr",   {59'd0, rf_waddr}, 64'd9);
        check_val("unstall_rf_we",   {63'd0, rf_we}, 64'd1);
        check_val("unstall_instret", instret, exp_cnt);

        // flush and stall together while MEM is valid
        drive_instr(5'd12, 2'd0, 3'd2, 2'd0, 32'hC, 32'h0, 32'h0, 32'h0);
        exp_q.push_back(32'hC);
        next_cycle();
        exp_cnt = exp_cnt + 1;
        flush = 1'b1;
        stall = 1'b1;
        drive_instr(5'd8, 2'd0, 3'd2, 2'd0, 32'h8, 32'h0, 32'h0, 32'h0);
        next_cycle();
        check_val("flush_rf_we",   {63'd0, rf_we}, 64'd0);
        check_val("flush_fwd",     {63'd0, fwd_valid}, 64'd0);
        check_val("flush_instret", instret, exp_cnt);
        flush = 1'b0;
        stall = 1'b0;
        drive_idle();
        next_cycle();
        check_val("idle_instret", instret, exp_cnt);

        // asynchronous reset between edges while WB holds a valid write
        drive_instr(5'd4, 2'd0, 3'd2, 2'd0, 32'h44, 32'h0, 32'h0, 32'h0);
        exp_q.push_back(32'h44);
        next_cycle();
        check_val("pre_rst_rf_we", {63'd0, rf_we}, 64'd1);
        drive_idle();
        #2;
        rst_n = 1'b0;
        #1;
        check_val("async_rst_rf_we",   {63'd0, rf_we}, 64'd0);
        check_val("async_rst_fwd",     {63'd0, fwd_valid}, 64'd0);
        check_val("async_rst_waddr",   {59'd0, rf_waddr}, 64'd0);
        check_val("async_rst_wdata",   {32'd0, rf_wdata}, 64'd0);
        check_val("async_rst_instret", instret, 64'd0);
        next_cycle();
        rst_n = 1'b1;
        next_cycle();

        // count restarts from zero
        drive_instr(5'd6, 2'd0, 3'd2, 2'd0, 32'h66, 32'h0, 32'h0, 32'h0);
        exp_q.push_back(32'h66);
        next_cycle();
        check_val("post_rst_instret", instret, 64'd1);
        drive_idle();
        next_cycle();

        check_val("exp_q_empty", 64'(exp_q.size()), 64'd0);

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule : tb_wb_stage_pipe
